ps2_keyboard_receiver: RTL and testbench



---
 rtl/ps2_keyboard_receiver.sv | 178 +++++++++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_keyboard_receiver: PS/2 frame receiver with make/break key decoding  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ps2_keyboard_receiver #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int c_FILT_W = $clog2(FILTER + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                r_clk_filt, r_filt_prev;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic [c_TO_W-1:0]   r_to_cnt, w_to_nx;
  state_t              r_state, w_state_nx;
  logic [2:0]          r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]          r_shift, w_shift_nx;
  logic                r_par_ok, w_par_ok_nx;
  logic                w_ok, w_perr, w_ferr;
  logic                r_pend_ext, r_pend_rel;
  logic                w_sample;

  // Synchronizers idle high, matching the released PS/2 bus.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_clk_filt  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_dat;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_clk_filt;
      if (r_clk_s2 != r_clk_filt) begin
        if (r_filt_cnt == c_FILT_W'(FILTER - 1)) begin
          r_clk_filt <= r_clk_s2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_sample = r_filt_prev & ~r_clk_filt;

  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_par_ok_nx  = r_par_ok;
    w_ok         = 1'b0;
    w_perr       = 1'b0;
    w_ferr       = 1'b0;
    if (r_state == ST_IDLE || w_sample) w_to_nx = '0;
    else                                w_to_nx = r_to_cnt + 1'b1;

    // A timeout wins over a coincident sample event.
    if (r_state != ST_IDLE && r_to_cnt == c_TO_W'(TIMEOUT)) begin
      w_state_nx = ST_IDLE;
      w_ferr     = 1'b1;
      w_to_nx    = '0;
    end else if (w_sample) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nx   = ST_DATA;
            w_bit_cnt_nx = 3'd0;
          end else begin
            w_ferr = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_nx = {r_dat_s2, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nx = ST_PARITY;
          else                   w_bit_cnt_nx = r_bit_cnt + 3'd1;
        end
        ST_PARITY: begin
          w_par_ok_nx = ^{r_shift, r_dat_s2};
          w_state_nx  = ST_STOP;
        end
        default: begin
          w_state_nx = ST_IDLE;
          if (!r_dat_s2)      w_ferr = 1'b1;
          else if (!r_par_ok) w_perr = 1'b1;
          else                w_ok   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_ok   <= 1'b0;
      r_to_cnt   <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_shift    <= w_shift_nx;
      r_par_ok   <= w_par_ok_nx;
      r_to_cnt   <= w_to_nx;
      byte_valid <= w_ok;
      parity_err <= w_perr;
      frame_err  <= w_ferr;
      if (w_ok) byte_data <= r_shift;
    end
  end

  // Prefix bytes only arm flags; any other byte completes a key event.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_pend_ext   <= 1'b0;
      r_pend_rel   <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_data == 8'hE0) begin
          r_pend_ext <= 1'b1;
        end else if (byte_data == 8'hF0) begin
          r_pend_rel <= 1'b1;
        end else begin
          key_code     <= byte_data;
          key_extended <= r_pend_ext;
          key_released <= r_pend_rel;
          key_valid    <= 1'b1;
          r_pend_ext   <= 1'b0;
          r_pend_rel   <= 1'b0;
        end
      end else if (parity_err || frame_err) begin
        r_pend_ext <= 1'b0;
        r_pend_rel <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_keyboard_receiver: scoreboard bench with randomized PS/2 frames   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ps2_keyboard_receiver;

  localparam int c_FILTER  = 8;
  localparam int c_TIMEOUT = 300;
  localparam int c_HALF    = 60;
  localparam int c_GAP     = 200;

  localparam int c_K_BYTE = 0;
  localparam int c_K_PAR  = 1;
  localparam int c_K_FRM  = 2;
  localparam int c_K_KEY  = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ps2_clk, ps2_dat;
  logic [7:0] byte_data, key_code;
  logic       byte_valid, key_extended, key_released, key_valid;
  logic       parity_err, frame_err;

  ps2_keyboard_receiver #(.FILTER(c_FILTER), .TIMEOUT(c_TIMEOUT)) u_dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_released(key_released),
    .key_valid   (key_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       ext;
    logic       rel;
  } ev_t;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         tolerate_frm = 1'b0;
  logic       prev_bv = 1'b0;
  logic [7:0] m_last_byte = 8'h00;
  bit         m_ext = 1'b0, m_rel = 1'b0;

  // Reference model: what the keyboard stream means, one frame at a time.
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    if (bad_stop || bad_par) begin
      sb.push_back('{bad_stop ? c_K_FRM : c_K_PAR, m_last_byte, 1'b0, 1'b0});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      m_last_byte = d;
      sb.push_back('{c_K_BYTE, d, 1'b0, 1'b0});
      if (d == 8'hE0)      m_ext = 1'b1;
      else if (d == 8'hF0) m_rel = 1'b1;
      else begin
        sb.push_back('{c_K_KEY, d, m_ext, m_rel});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
  endtask

  task automatic model_abort();
    sb.push_back('{c_K_FRM, m_last_byte, 1'b0, 1'b0});
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  task automatic build(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                       output logic [10:0] b);
    b[0]   = 1'b0;
    b[8:1] = d;
    b[9]   = (~^d) ^ bad_par;
    b[10]  = ~bad_stop;
  endtask

  task automatic send_range(input logic [10:0] b, input int lo, input int hi, input bit glitch);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      ps2_dat = b[i];
      if (glitch && i > 0) begin
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (c_HALF - 25) @(negedge clk);
      end else begin
        repeat (c_HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (c_HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic [10:0] b;
    build(d, bad_par, bad_stop, b);
    model_frame(d, bad_par, bad_stop);
    send_range(b, 0, 10, glitch);
    ps2_dat = 1'b1;
    repeat (c_GAP) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain_%s: %0d events still expected, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name, input logic [7:0] v);
    n_checks++;
    if (v !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_%s: actual %02h, required 00", name, v);
    end
  endtask

  task automatic check_all_zero();
    check_zero("byte_data", byte_data);
    check_zero("byte_valid", {7'd0, byte_valid});
    check_zero("key_code", key_code);
    check_zero("key_flags", {6'd0, key_extended, key_released});
    check_zero("key_valid", {7'd0, key_valid});
    check_zero("parity_err", {7'd0, parity_err});
    check_zero("frame_err", {7'd0, frame_err});
  endtask

  task automatic score(input string name, input int kind, input logic [7:0] d,
                       input logic e, input logic r);
    ev_t x;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s: unexpected event kind=%0d data=%02h, required none", name, kind, d);
    end else begin
      x = sb.pop_front();
      if (x.kind != kind || x.data !== d || x.ext !== e || x.rel !== r) begin
        n_errors++;
        $display("FAIL %s: actual kind=%0d data=%02h ext=%b rel=%b, required kind=%0d data=%02h ext=%b rel=%b",
                 name, kind, d, e, r, x.kind, x.data, x.ext, x.rel);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, pops the scoreboard on every DUT event.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_bv <= 1'b0;
    end else begin
      if (int'(byte_valid) + int'(parity_err) + int'(frame_err) > 1) begin
        n_checks++;
        n_errors++;
        $display("FAIL exclusive: bv=%b pe=%b fe=%b, required at most one", byte_valid,
                 parity_err, frame_err);
      end
      if (key_valid) begin
        n_checks++;
        if (!prev_bv) begin
          n_errors++;
          $display("FAIL key_latency: byte_valid previous cycle=%b, required 1", prev_bv);
        end
        score("key_event", c_K_KEY, key_code, key_extended, key_released);
      end
      if (byte_valid) score("byte_event", c_K_BYTE, byte_data, 1'b0, 1'b0);
      if (parity_err) score("parity_event", c_K_PAR, byte_data, 1'b0, 1'b0);
      if (frame_err && !tolerate_frm) score("frame_event", c_K_FRM, byte_data, 1'b0, 1'b0);
      prev_bv <= byte_valid;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] b;
    logic [7:0]  d;
    int          r, e;
    resetn  = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    #1 check_all_zero();
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    wait_drain("basic");

    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    wait_drain("prefixes");

    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_drain("errors");

    // Partial frame followed by silence.
    build(8'h55, 1'b0, 1'b0, b);
    model_abort();
    send_range(b, 0, 4, 1'b0);
    ps2_dat = 1'b1;
    repeat (c_TIMEOUT + 10) @(negedge clk);
    wait_drain("timeout");
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    wait_drain("after_timeout");

    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    wait_drain("glitch");

    // Reset in the middle of a frame; leftover bits may only raise frame_err.
    build(8'h1C, 1'b0, 1'b0, b);
    send_range(b, 0, 3, 1'b0);
    tolerate_frm = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1 check_all_zero();
    m_last_byte = 8'h00;
    m_ext = 1'b0;
    m_rel = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    send_range(b, 4, 10, 1'b0);
    ps2_dat = 1'b1;
    repeat (c_TIMEOUT + 100) @(negedge clk);
    tolerate_frm = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    wait_drain("after_reset");

    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      d = 8'hE0;
      else if (r < 4) d = 8'hF0;
      else            d = 8'($urandom_range(0, 255));
      e = $urandom_range(0, 9);
      send_frame(d, e == 0 || e == 2, e == 1 || e == 2, 1'b0);
    end
    wait_drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
